// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty levels,
// occupancy count, non-power-of-2 depth and optional first-word-fall-through reads.
module sync_fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  output logic             o_wr_ack,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almostfull,
  output logic             o_almostempty,
  output logic [CW-1:0]    o_count
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_wr_ack, r_overflow, r_underflow;
  logic             w_rd_acc, w_wr_acc;

  assign o_full        = (r_count == DEPTH_C);
  assign o_empty       = (r_count == '0);
  assign o_almostfull  = (r_count >= AF_C);
  assign o_almostempty = (r_count <= AE_C);
  assign o_count       = r_count;
  assign o_wr_ack      = r_wr_ack;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign w_rd_acc = i_rd_en && !o_empty;
  assign w_wr_acc = i_wr_en && (!o_full || w_rd_acc);

  always_ff @(posedge i_clk) begin
    if (w_wr_acc && !i_rst) r_mem[r_wr_ptr] <= i_data_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wr_ack    <= w_wr_acc;
      r_overflow  <= i_wr_en && !w_wr_acc;
      r_underflow <= i_rd_en && o_empty;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] r_dout;
      logic             r_valid;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign o_data_out = r_dout;
      assign o_valid    = r_valid;
    end else begin : g_fwft
      // Head word is shown directly; visibility follows the registered count.
      assign o_data_out = r_mem[r_rd_ptr];
      assign o_valid    = !o_empty;
    end
  endgenerate

endmodule
